// File: rtl/mpq_cmd_arbiter_if.sv
// mpq_cmd_arbiter_if: requester-side and engine-side command signals of the arbiter
interface mpq_cmd_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_cmd;
  logic [8*NREQ-1:0] req_index;
  logic [8*NREQ-1:0] req_value;
  logic [NREQ-1:0]   rsp_done;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [7:0]        index;
  logic [7:0]        value;
  logic              mpq_busy;
  logic              mpq_done;
  modport master (
    input  req_valid, req_cmd, req_index, req_value, mpq_busy, mpq_done,
    output req_ready, rsp_done, cmd_valid, cmd, index, value
  );
  modport slave (
    output req_valid, req_cmd, req_index, req_value, mpq_busy, mpq_done,
    input  req_ready, rsp_done, cmd_valid, cmd, index, value
  );
endinterface

// File: rtl/mpq_cmd_arbiter.sv
// mpq_cmd_arbiter: round-robin sharing of the max-priority-queue command port among NREQ requesters.
// Optional watchdog with sticky to_err output enabled by MPQ_ARB_TIMEOUT_EN.
module mpq_cmd_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int TO_CYCLES = 64,
  localparam int OW        = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  mpq_cmd_arbiter_if.master   bus,
  output logic [OW-1:0]       cur_owner,
  output logic [15:0]         cmd_cnt
`ifdef MPQ_ARB_TIMEOUT_EN
  , output logic              to_err
`endif
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, WAIT_DONE, RESP} state_t;
  state_t state_q, state_d;
  logic [OW-1:0] rr_q, rr_d, owner_q, owner_d, win;
  logic [2:0] cmd_q, cmd_d, sel_cmd;
  logic [7:0] index_q, index_d, value_q, value_d, sel_index, sel_value;
  logic [15:0] cnt_q, cnt_d;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic [OW:0] pos;
  logic found, grant, timeout;
`ifdef MPQ_ARB_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic to_err_q, to_err_d;
`endif
  // Rotate so bit 0 is the rr_ptr requester; the lowest set bit is the winner.
  always_comb begin
    dbl = {bus.req_valid, bus.req_valid} >> rr_q;
    rot = dbl[NREQ-1:0];
    found = 1'b0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        pos = (OW+1)'(k);
      end
    pos = pos + {1'b0, rr_q};
    win = (pos >= (OW+1)'(NREQ)) ? OW'(pos - (OW+1)'(NREQ)) : OW'(pos);
    sel_cmd = '0;
    sel_index = '0;
    sel_value = '0;
    for (int k = 0; k < NREQ; k++)
      if (win == OW'(k)) begin
        sel_cmd = bus.req_cmd[3*k +: 3];
        sel_index = bus.req_index[8*k +: 8];
        sel_value = bus.req_value[8*k +: 8];
      end
  end
  assign grant = (state_q == IDLE) && en && !bus.mpq_busy && found;
`ifdef MPQ_ARB_TIMEOUT_EN
  assign timeout = (state_q inside {WAIT_HI, WAIT_LO, WAIT_DONE}) && (wd_q == 16'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = grant ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_HI;
      WAIT_HI:   state_d = !bus.mpq_busy ? WAIT_HI : (cmd_q == 3'd4) ? WAIT_DONE : WAIT_LO;
      WAIT_LO:   state_d = bus.mpq_busy ? WAIT_LO : RESP;
      WAIT_DONE: state_d = bus.mpq_done ? RESP : WAIT_DONE;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (timeout) state_d = RESP;
  end
  always_comb begin
    bus.req_ready = grant ? NREQ'(1) << win : '0;
    bus.rsp_done  = (state_q == RESP) ? NREQ'(1) << owner_q : '0;
    bus.cmd_valid = state_q == ISSUE;
    bus.cmd       = cmd_q;
    bus.index     = index_q;
    bus.value     = value_q;
    cur_owner     = owner_q;
    cmd_cnt       = cnt_q;
  end
  always_comb begin
    rr_d    = grant ? ((win == OW'(NREQ - 1)) ? '0 : win + OW'(1)) : rr_q;
    owner_d = grant ? win : owner_q;
    cmd_d   = grant ? sel_cmd : cmd_q;
    index_d = grant ? sel_index : index_q;
    value_d = grant ? sel_value : value_q;
    cnt_d   = (state_q == RESP) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_q    <= '0;
      owner_q <= '0;
      cmd_q   <= '0;
      index_q <= '0;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      index_q <= index_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
`ifdef MPQ_ARB_TIMEOUT_EN
  always_comb begin
    wd_d = (state_q == ISSUE) ? '0 : (state_q inside {WAIT_HI, WAIT_LO, WAIT_DONE}) ? wd_q + 16'd1 : wd_q;
    to_err_d = to_err_q | timeout;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      to_err_q <= to_err_d;
    end
  assign to_err = to_err_q;
`endif
endmodule

// File: tb/tb_mpq_cmd_arbiter.sv
// tb_mpq_cmd_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mpq_cmd_arbiter;
  localparam int N = 4;
  logic clk, rst, en;
  logic [1:0] cur_owner;
  logic [15:0] cmd_cnt;
`ifdef MPQ_ARB_TIMEOUT_EN
  logic to_err;
`endif
  int checks = 0, failures = 0;
  mpq_cmd_arbiter_if #(.NREQ(N)) bus ();
  mpq_cmd_arbiter #(.NREQ(N), .TO_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .cur_owner(cur_owner), .cmd_cnt(cmd_cnt)
`ifdef MPQ_ARB_TIMEOUT_EN
    , .to_err(to_err)
`endif
  );
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [2:0] c, input logic [7:0] x, input logic [7:0] y);
    bus.req_cmd[3*i +: 3] = c;
    bus.req_index[8*i +: 8] = x;
    bus.req_value[8*i +: 8] = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    bus.req_valid = '0;
    bus.mpq_busy = 0;
    bus.mpq_done = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    checks++;
    if ({bus.cmd_valid, bus.cmd, bus.index, bus.value, bus.rsp_done, bus.req_ready, cur_owner, cmd_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got cv=%b cmd=%0d idx=%0d val=%0d rsp=%b rdy=%b own=%0d cnt=%0d exp all 0",
               bus.cmd_valid, bus.cmd, bus.index, bus.value, bus.rsp_done, bus.req_ready, cur_owner, cmd_cnt);
    end
`ifdef MPQ_ARB_TIMEOUT_EN
    checks++;
    if (to_err !== 1'b0) begin failures++; $display("FAIL reset_to_err got %b exp 0", to_err); end
`endif
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_single_grant();
    @(negedge clk);
    set_req(0, 3'd2, 8'd5, 8'h40);
    bus.req_valid = 4'b0001;
    en = 1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL sg_ready got %b exp 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++;
    if ({bus.cmd_valid, bus.cmd, bus.index, bus.value} !== {1'b1, 3'd2, 8'd5, 8'h40}) begin
      failures++;
      $display("FAIL sg_issue got cv=%b cmd=%0d idx=%0d val=%h exp 1/2/5/40", bus.cmd_valid, bus.cmd, bus.index, bus.value);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.mpq_busy = (k < 3);
      #1;
      checks++;
      if (bus.rsp_done !== ((k == 4) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL sg_rsp k=%0d got %b exp %b", k, bus.rsp_done, (k == 4) ? 4'b0001 : 4'b0000);
      end
    end
    checks++;
    if (cmd_cnt !== 16'd1) begin failures++; $display("FAIL sg_cnt got %0d exp 1", cmd_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'(i), 8'(i), 8'(i));
    for (int g = 0; g < 5; g++) begin
      bit got = 0;
      for (int t = 0; t < 12 && !got; t++) begin
        @(negedge clk);
        bus.req_valid = 4'b1111;
        bus.mpq_busy = 0;
        #1;
        got = (bus.req_ready != 0);
      end
      checks++;
      if (bus.req_ready !== 4'(1 << (g % N))) begin
        failures++;
        $display("FAIL rr_grant g=%0d got %b exp %b", g, bus.req_ready, 4'(1 << (g % N)));
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.cmd_valid, cur_owner} !== {1'b1, 2'(g % N)}) begin
        failures++;
        $display("FAIL rr_owner g=%0d got cv=%b own=%0d exp 1/%0d", g, bus.cmd_valid, cur_owner, g % N);
      end
      repeat (2) begin @(negedge clk); bus.mpq_busy = 1; end
    end
    @(negedge clk);
    bus.mpq_busy = 0;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_gating();
    en = 0;
    set_req(2, 3'd1, 8'h22, 8'h33);
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.req_ready, bus.cmd_valid} !== 5'b0) begin
        failures++;
        $display("FAIL gate_hold k=%0d got rdy=%b cv=%b exp 0/0", k, bus.req_ready, bus.cmd_valid);
      end
    end
    @(negedge clk);
    en = 1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL gate_grant got %b exp 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    bus.mpq_busy = 1;
    @(negedge clk);
    bus.mpq_busy = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_writeout();
    logic [7:0] wb = 8'b0011_0011, wd = 8'b0100_0000;
    @(negedge clk);
    set_req(3, 3'd4, 8'h77, 8'h88);
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL wo_ready got %b exp 1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.mpq_busy = wb[k];
      bus.mpq_done = wd[k];
      #1;
      checks++;
      if (bus.rsp_done !== ((k == 7) ? 4'b1000 : 4'b0000)) begin
        failures++;
        $display("FAIL wo_rsp k=%0d got %b exp %b", k, bus.rsp_done, (k == 7) ? 4'b1000 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(0, 3'd1, 8'h11, 8'h99);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) begin @(negedge clk); bus.mpq_busy = 1; end
    #1;
    rst = 0;
    #1;
    checks++;
    if ({bus.cmd_valid, bus.cmd, bus.index, bus.value, bus.rsp_done, bus.req_ready, cur_owner, cmd_cnt} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got cv=%b cmd=%0d idx=%0d val=%0d rsp=%b own=%0d cnt=%0d exp all 0",
               bus.cmd_valid, bus.cmd, bus.index, bus.value, bus.rsp_done, cur_owner, cmd_cnt);
    end
    @(negedge clk);
    rst = 1;
    bus.mpq_busy = 0;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_rrptr got %b exp 0001", bus.req_ready); end
  endtask

`ifdef MPQ_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    set_req(1, 3'd0, 8'h01, 8'h02);
    bus.req_valid = 4'b0010;
    en = 1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL to_ready got %b exp 0010", bus.req_ready); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checks++;
      if ({bus.rsp_done, to_err} !== {(k == 10) ? 4'b0010 : 4'b0000, k >= 10}) begin
        failures++;
        $display("FAIL to_cycle k=%0d got rsp=%b err=%b exp rsp=%b err=%b", k, bus.rsp_done, to_err,
                 (k == 10) ? 4'b0010 : 4'b0000, k >= 10);
      end
    end
  endtask
`endif

  task automatic test_random(input int ncyc);
    logic [N-1:0] v = '0;
    logic [2:0] rc[N];
    logic [7:0] ri[N], rv[N];
    logic [1:0] eq[$];
    logic [2:0] ecmd = 0;
    logic [7:0] eidx = 0, eval = 0;
    bit outst = 0, iss = 0;
    int rr = 0, owner = 0, cnt = 0, rsp_at = -1;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      logic [N-1:0] exp_rdy, exp_rsp;
      int w;
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1;
          rc[i] = 3'($urandom_range(0, 7));
          ri[i] = 8'($urandom);
          rv[i] = 8'($urandom);
          set_req(i, rc[i], ri[i], rv[i]);
        end
      bus.req_valid = v;
      en = ($urandom_range(0, 7) != 0);
      if (eq.size() > 0) {bus.mpq_done, bus.mpq_busy} = eq.pop_front();
      else {bus.mpq_done, bus.mpq_busy} = 2'b00;
      #1;
      exp_rdy = '0;
      w = -1;
      if (!outst && en && !bus.mpq_busy)
        for (int k = 0; k < N; k++)
          if (w < 0 && v[(rr + k) % N]) w = (rr + k) % N;
      if (w >= 0) exp_rdy = 4'(1 << w);
      exp_rsp = (c == rsp_at) ? 4'(1 << owner) : '0;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d got %b exp %b", c, bus.req_ready, exp_rdy);
      end
      checks++;
      if ({bus.cmd_valid, bus.cmd, bus.index, bus.value} !== {iss, ecmd, eidx, eval}) begin
        failures++;
        $display("FAIL rnd_cmd cyc=%0d got %b/%0d/%h/%h exp %b/%0d/%h/%h", c, bus.cmd_valid, bus.cmd,
                 bus.index, bus.value, iss, ecmd, eidx, eval);
      end
      checks++;
      if (bus.rsp_done !== exp_rsp) begin
        failures++;
        $display("FAIL rnd_rsp cyc=%0d got %b exp %b", c, bus.rsp_done, exp_rsp);
      end
      checks++;
      if ({cur_owner, cmd_cnt} !== {2'(owner), 16'(cnt)}) begin
        failures++;
        $display("FAIL rnd_owner_cnt cyc=%0d got %0d/%0d exp %0d/%0d", c, cur_owner, cmd_cnt, owner, cnt);
      end
      if (iss) begin
        int d = $urandom_range(0, (ecmd == 3'd4) ? 1 : 2);
        repeat (d) eq.push_back(2'b00);
        if (ecmd == 3'd4) begin
          int n1 = $urandom_range(1, 2), n2 = $urandom_range(1, 2);
          repeat (n1) eq.push_back(2'b01);
          eq.push_back(2'b00);
          repeat (n2) eq.push_back(2'b01);
          eq.push_back(2'b10);
          rsp_at = c + d + n1 + 1 + n2 + 2;
        end else begin
          int n = $urandom_range(1, 3);
          repeat (n) eq.push_back(2'b01);
          rsp_at = c + d + n + 2;
        end
      end
      iss = 0;
      if (c == rsp_at) begin
        outst = 0;
        cnt++;
        rsp_at = -1;
      end
      if (w >= 0) begin
        outst = 1;
        iss = 1;
        owner = w;
        ecmd = rc[w];
        eidx = ri[w];
        eval = rv[w];
        rr = (w + 1) % N;
        v[w] = 0;
      end
    end
  endtask

  initial begin
    clk = 0;
    rst = 0;
    en = 0;
    bus.req_valid = '0;
    bus.req_cmd = '0;
    bus.req_index = '0;
    bus.req_value = '0;
    bus.mpq_busy = 0;
    bus.mpq_done = 0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_gating();
    test_writeout();
    test_reset_mid();
    test_random(3000);
`ifdef MPQ_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mpq_cmd_arbiter.md
Name: mpq_cmd_arbiter

Overview:
- Shares the single command port of the max-priority-queue engine (cmd_valid/cmd/index/value, busy, done) between NREQ independent requesters.
- Grants one requester at a time, round-robin. Issues a one-cycle cmd_valid pulse to the engine, tracks completion from its busy/done outputs, and returns a per-requester completion pulse.
- Sits between the command-generating blocks and the engine.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OW, $clog2(NREQ), owner-id width (derived, not overridden).
- TO_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; low holds arbiter in IDLE (engine still loading).
- req_valid  input  NREQ  request pending, bit i for requester i.
- req_ready  output  NREQ  one-hot accept (combinational), asserted only in IDLE.
- req_cmd  input  3*NREQ  packed 3-bit opcodes; requester i at [3i+2:3i].
- req_index  input  8*NREQ  packed 8-bit index fields.
- req_value  input  8*NREQ  packed 8-bit value fields.
- rsp_done  output  NREQ  one-cycle completion pulse to the owner.
- cmd_valid  output  1  registered command strobe to the engine.
- cmd  output  3  registered opcode.
- index  output  8  registered index.
- value  output  8  registered value.
- mpq_busy  input  1  engine busy.
- mpq_done  input  1  engine write-out complete.
- cur_owner  output  OW  id of the current/last granted requester.
- cmd_cnt  output  16  count of completed commands; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, cmd_valid=0, cmd=0, index=0, value=0, rsp_done=0, cur_owner=0, cmd_cnt=0.
- Arbitration:
  - In IDLE with en=1 and mpq_busy=0, the winner is the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ.
  - req_ready[winner]=1 in that same cycle; all other req_ready bits are 0. req_ready=0 in every other state and whenever en=0.
  - At the accepting edge: latch the winner's cmd/index/value into the outputs, cur_owner<=winner, rr_ptr<=(winner+1) mod NREQ, go to ISSUE.
- IDLE: holds while en=0, mpq_busy=1, or no request is valid. A request must stay valid and stable until req_ready is seen.
- ISSUE: cmd_valid=1 for exactly this one cycle, then WAIT_HI. cmd_valid=0 in all other states.
- WAIT_HI: waits for mpq_busy=1 (normally the first WAIT_HI cycle, since the engine registers busy on the same edge it samples cmd_valid).
  - On mpq_busy=1 with cmd==4 (write-out): go to WAIT_DONE.
  - On mpq_busy=1 with any other cmd: go to WAIT_LO.
- WAIT_LO: on mpq_busy=0 go to RESP.
- WAIT_DONE: on mpq_done=1 go to RESP. mpq_busy toggles during the engine's reset/reload are ignored here.
- RESP: rsp_done[cur_owner]=1 for exactly one cycle, cmd_cnt<=cmd_cnt+1, then IDLE.
- At most one command is outstanding at any time. The latched cmd/index/value hold their values between commands.
- cmd values 5..7 are forwarded unchanged and complete via WAIT_LO.
- en falling mid-command does not abort; it only blocks the next grant.
- Reset mid-command returns to IDLE at once; the pending rsp_done is lost and the requester must re-request.

Optional Feature:
- Macro: MPQ_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in WAIT_HI, WAIT_LO or WAIT_DONE; it clears on entering ISSUE.
  - When it reaches TO_CYCLES: go to RESP (owner still gets rsp_done) and set sticky output to_err=1.
  - to_err clears only on reset; its reset value is 0.
- Not defined: no watchdog and no to_err port; the arbiter waits indefinitely.

Test Plan:
- Single grant: en=1, req_valid=0001, cmd=2, index=5, value=0x40 -> req_ready=0001 for 1 cycle; next cycle cmd_valid=1, cmd=2, index=5, value=0x40; mpq_busy 1 for 3 cycles then 0 -> rsp_done=0001 one cycle later, cmd_cnt=1.
- Round-robin: req_valid=1111 held, each busy pulse 2 cycles -> grants in order 0,1,2,3,0; cur_owner follows that sequence.
- Gating: en=0 with req_valid=0100 -> req_ready stays 0 and cmd_valid=0; raise en -> grant to 2 in the same cycle en is sampled high.
- Write-out: cmd=4 from requester 3; busy rises, falls, rises again, then mpq_done=1 -> rsp_done[3] only after mpq_done; no completion on the intermediate busy fall.
- Reset: rst=0 asserted in WAIT_LO -> all outputs return to reset values asynchronously; after release, state is IDLE and rr_ptr=0.
- Timeout (MPQ_ARB_TIMEOUT_EN, TO_CYCLES=8): mpq_busy held 0 after ISSUE -> RESP after 8 WAIT_HI cycles, rsp_done pulses, to_err=1 and stays 1.
